mem_access_ctrl: RTL and testbench

Single-port access sequencer on the initiator side of the unified instruction/data word memory in the multicycle MIPS datapath. It accepts one instruction-fetch or data load/store request per transaction from the control unit and drives the memory's address, write-data and read/write lines. It captures the memory's combinational read data and returns it with a one-cycle response pulse. It converts byte addresses to word indices and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-port access sequencer for the unified MIPS word memory.
// Turns one fetch or load/store request into a memory cycle and a one-cycle response.
module mem_access_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_is_fetch,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | ready for a new request
  // ACCESS | memory read or write in progress (one cycle)
  // RESP   | resp_valid pulse, then back to IDLE
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic        is_fetch_q, is_fetch_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_is_fetch_q, resp_is_fetch_d;
  logic        resp_fault_q, resp_fault_d;

  logic          accept;
  logic [31:0]   req_addr;
  logic [AW-1:0] req_idx;
  logic          req_fault;

  assign accept    = (state_q == S_IDLE) & (data_req | fetch_req);
  assign req_addr  = data_req ? data_addr : fetch_pc;
  assign req_idx   = req_addr[AW+1:2];
  // Anything at or above 4*DEPTH_WORDS has a nonzero bit above the index field.
  assign req_fault = (req_addr[1:0] != 2'b00) | (|req_addr[31:AW+2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      is_store_q      <= 1'b0;
      is_fetch_q      <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      resp_data_q     <= '0;
      resp_is_fetch_q <= 1'b0;
      resp_fault_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_store_q      <= is_store_d;
      is_fetch_q      <= is_fetch_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      resp_data_q     <= resp_data_d;
      resp_is_fetch_q <= resp_is_fetch_d;
      resp_fault_q    <= resp_fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = req_fault ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    is_store_d      = is_store_q;
    is_fetch_d      = is_fetch_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    resp_data_d     = resp_data_q;
    resp_is_fetch_d = resp_is_fetch_q;
    resp_fault_d    = resp_fault_q;
    if (accept) begin
      is_store_d = data_req & data_we;
      is_fetch_d = ~data_req;
      if (!req_fault) begin
        mem_addr_d = {{(32-AW){1'b0}}, req_idx};
        if (data_req & data_we) mem_wdata_d = data_wdata;
      end else begin
        // Faults skip ACCESS, so the response fields are loaded straight away.
        resp_data_d     = '0;
        resp_is_fetch_d = ~data_req;
        resp_fault_d    = 1'b1;
      end
    end
    if (state_q == S_ACCESS) begin
      resp_data_d     = is_store_q ? 32'h0 : mem_rdata;
      resp_is_fetch_d = is_fetch_q;
      resp_fault_d    = 1'b0;
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    mem_rw     = (state_q == S_ACCESS) & is_store_q;
  end

  assign resp_data     = resp_data_q;
  assign resp_is_fetch = resp_is_fetch_q;
  assign resp_fault    = resp_fault_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: attached word memory plus a transaction-level
// reference (shadow memory and address rules).
module tb_mem_access_ctrl;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        req_ready, resp_valid, resp_is_fetch, resp_fault, mem_rw;
  logic [31:0] resp_data, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_is_fetch(resp_is_fetch), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_rw) mem[mem_addr[9:0]] <= mem_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction, started and finished on a falling edge.
  task automatic run_txn(input bit is_data, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
    bit          exp_fault;
    bit          exp_store;
    int          idx;
    int          n;
    int          rw_cnt;
    logic [31:0] rw_addr;
    logic [31:0] exp_data;
    exp_fault = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
    exp_store = is_data && we && !exp_fault;
    idx       = exp_fault ? 0 : int'(addr >> 2);
    exp_data  = 32'h0;
    if (!exp_fault) begin
      if (is_data && we) ref_mem[idx] = wd;
      else exp_data = ref_mem[idx];
    end
    data_req   = is_data;
    fetch_req  = !is_data;
    data_we    = is_data ? we : 1'($urandom);
    data_addr  = is_data ? addr : $urandom;
    fetch_pc   = is_data ? $urandom : addr;
    data_wdata = wd;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    n = 0; rw_cnt = 0; rw_addr = '0;
    do begin
      @(negedge clk);
      n++;
      if (mem_rw) begin rw_cnt++; rw_addr = mem_addr; end
      check({tag, ".busy"}, 32'(req_ready), 32'd0);
      data_req  = 1'b0;
      fetch_req = resp_valid ? 1'b0 : 1'($urandom);
    end while (!resp_valid && n < 5);
    fetch_req = 1'b0;
    check({tag, ".latency"}, 32'(n), exp_fault ? 32'd1 : 32'd2);
    check({tag, ".data"}, resp_data, exp_data);
    check({tag, ".fault"}, 32'(resp_fault), 32'(exp_fault));
    check({tag, ".is_fetch"}, 32'(resp_is_fetch), 32'(!is_data));
    check({tag, ".rw_cycles"}, 32'(rw_cnt), exp_store ? 32'd1 : 32'd0);
    if (exp_store) check({tag, ".rw_addr"}, rw_addr, 32'(idx));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    check({tag, ".idle"}, 32'(req_ready), 32'd1);
    if (!exp_fault) check({tag, ".mem"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int          mism;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[0] = 32'h2008000A;
    ref_mem[0] = 32'h2008000A;

    repeat (2) @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.valid", 32'(resp_valid), 32'd0);
    check("rst.data", resp_data, 32'h0);
    check("rst.is_fetch", 32'(resp_is_fetch), 32'd0);
    check("rst.fault", 32'(resp_fault), 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.mem_rw", 32'(mem_rw), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1, 1, 32'h10, 32'hDEADBEEF, "store10");
    run_txn(1, 0, 32'h10, 32'h0, "load10");
    check("load10.value", resp_data, 32'hDEADBEEF);
    run_txn(0, 0, 32'h0, 32'h0, "fetch0");
    check("fetch0.value", resp_data, 32'h2008000A);

    // Data and fetch together: data first, fetch accepted three edges later.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8;
    fetch_req = 1'b1; fetch_pc = 32'h4;
    check("dual.ready0", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("dual.access0", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("dual.valid0", 32'(resp_valid), 32'd1);
    check("dual.is_fetch0", 32'(resp_is_fetch), 32'd0);
    check("dual.data0", resp_data, ref_mem[2]);
    data_req = 1'b0;
    @(negedge clk);
    check("dual.ready1", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("dual.access1", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("dual.valid1", 32'(resp_valid), 32'd1);
    check("dual.is_fetch1", 32'(resp_is_fetch), 32'd1);
    check("dual.data1", resp_data, ref_mem[1]);
    fetch_req = 1'b0;
    @(negedge clk);

    run_txn(1, 1, 32'h6, 32'hCAFEF00D, "store6");
    check("store6.word1", mem[1], ref_mem[1]);
    run_txn(1, 0, 32'hFFC, 32'h0, "loadFFC");
    run_txn(1, 0, 32'h1000, 32'h0, "load1000");
    run_txn(1, 0, 32'h8000_0010, 32'h0, "loadbit31");
    run_txn(0, 0, 32'h2, 32'h0, "fetchmis");
    run_txn(1, 0, 32'h40, 32'h0, "loadnz");

    // Reset in the middle of a store's ACCESS cycle.
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    check("rststore.rw_hi", 32'(mem_rw), 32'd1);
    check("rststore.addr", mem_addr, 32'd8);
    data_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rststore.rw_lo", 32'(mem_rw), 32'd0);
    check("rststore.ready", 32'(req_ready), 32'd1);
    check("rststore.valid", 32'(resp_valid), 32'd0);
    check("rststore.data", resp_data, 32'h0);
    check("rststore.fault", 32'(resp_fault), 32'd0);
    check("rststore.mem_addr", mem_addr, 32'h0);
    check("rststore.mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    check("rststore.noresp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rststore.word8", mem[8], ref_mem[8]);
    @(negedge clk);
    check("rststore.after", 32'(resp_valid), 32'd0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        6:       a = ($urandom_range(0, DEPTH - 1) << 2) | 32'($urandom_range(1, 3));
        7:       a = 32'(4 * DEPTH) + ($urandom_range(0, 255) << 2);
        8:       a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
        9:       a = 32'(4 * DEPTH - 4);
        default: a = $urandom_range(0, DEPTH - 1) << 2;
      endcase
      run_txn(bit'($urandom_range(0, 2) != 0), 1'($urandom), a, $urandom, "rand");
    end

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_final", 32'(mism), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
